// File: rtl/fp16_pkg.sv
// fp16_pkg: shared FP16 field widths, flag indices and FIFO entry types used
// by the adder result FIFO and its classifier.
package fp16_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int FP_W  = 16;
  localparam int FLG_W = 4;

  localparam logic [EXP_W-1:0] EXP_MAX = 5'd31;

  // Bit positions inside the 4-bit flag vector {nan,inf,sub,zero}
  localparam int FLG_ZERO = 0;
  localparam int FLG_SUB  = 1;
  localparam int FLG_INF  = 2;
  localparam int FLG_NAN  = 3;

  typedef logic [FLG_W-1:0] fp16_flags_t;

  // Value class of one FP16 result
  typedef enum logic [2:0] {
    FPC_NORMAL = 3'd0,
    FPC_ZERO   = 3'd1,
    FPC_SUB    = 3'd2,
    FPC_INF    = 3'd3,
    FPC_NAN    = 3'd4
  } fp16_class_t;

  // One FIFO slot: flags travel alongside the packed word
  typedef struct packed {
    fp16_flags_t       flags;
    logic [FP_W-1:0]   word;
  } fifo_entry_t;

  // Pack sign/exponent/mantissa into the IEEE half-precision layout
  function automatic logic [FP_W-1:0] fp16_pack(
    input logic             s,
    input logic [EXP_W-1:0] e,
    input logic [MAN_W-1:0] m
  );
    return {s, e, m};
  endfunction

endpackage

// File: rtl/fp16_classify.sv
// fp16_classify: combinational packer/classifier for one adder result.
// With FP16_FTZ_EN defined, subnormals are flushed to a signed zero and
// reported with the zero flag; otherwise they pass through with the sub flag.
module fp16_classify
  import fp16_pkg::*;
(
  input  logic             s,
  input  logic [EXP_W-1:0] e,
  input  logic [MAN_W-1:0] m,
  output logic [FP_W-1:0]  word,
  output fp16_flags_t      flags
);

  fp16_class_t cls;

  // Decode the exponent/mantissa pair into a value class
  always_comb begin
    cls = FPC_NORMAL;
    if (e == EXP_MAX) begin
      if (m != {MAN_W{1'b0}}) begin
        cls = FPC_NAN;
      end else begin
        cls = FPC_INF;
      end
    end else if (e == {EXP_W{1'b0}}) begin
      if (m != {MAN_W{1'b0}}) begin
        cls = FPC_SUB;
      end else begin
        cls = FPC_ZERO;
      end
    end else begin
      cls = FPC_NORMAL;
    end
  end

  // Produce the stored word and its one-hot (or empty) flag vector
  always_comb begin
    word  = fp16_pack(s, e, m);
    flags = {FLG_W{1'b0}};
    case (cls)
      FPC_ZERO: flags[FLG_ZERO] = 1'b1;
      FPC_SUB: begin
`ifdef FP16_FTZ_EN
        word            = {s, {(FP_W-1){1'b0}}};
        flags[FLG_ZERO] = 1'b1;
`else
        flags[FLG_SUB] = 1'b1;
`endif
      end
      FPC_INF:    flags[FLG_INF] = 1'b1;
      FPC_NAN:    flags[FLG_NAN] = 1'b1;
      FPC_NORMAL: flags = {FLG_W{1'b0}};
      default:    flags = {FLG_W{1'b0}};
    endcase
  end

endmodule

// File: rtl/fp16_add_result_fifo.sv
// fp16_add_result_fifo: result collector behind a fixed-latency FP16 adder.
// A shift register marks which adder output cycles carry real results; those
// results are classified, stored in a small FIFO and drained by a valid/ready
// consumer. Credits (issue_ready) keep stored + in-flight results <= DEPTH.
// Optional build macro: FP16_FTZ_EN (flush subnormals to signed zero).
module fp16_add_result_fifo
  import fp16_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue,
  output logic                         issue_ready,
  input  logic                         res_s,
  input  logic [EXP_W-1:0]             res_e,
  input  logic [MAN_W-1:0]             res_m,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [FP_W-1:0]              out_data,
  output fp16_flags_t                  out_flags,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         drop_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int IF_W  = $clog2(LATENCY + 1);
  localparam int SUM_W = ((CNT_W > IF_W) ? CNT_W : IF_W) + 1;

  logic [LATENCY-1:0] vpipe;
  logic [IF_W-1:0]    inflight;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  fifo_entry_t        mem [DEPTH];

  logic               arrive;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;
  logic [FP_W-1:0]    cls_word;
  fp16_flags_t        cls_flags;
  fifo_entry_t        new_entry;
  logic [CNT_W-1:0]   count_nxt;
  logic [PTR_W-1:0]   rd_nxt;
  fifo_entry_t        head_nxt;

  fp16_classify u_classify (
    .s     (res_s),
    .e     (res_e),
    .m     (res_m),
    .word  (cls_word),
    .flags (cls_flags)
  );

  assign arrive    = vpipe[LATENCY-1];
  assign full      = (count == CNT_W'(DEPTH));
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a result when the head leaves on the same edge
  assign push      = arrive && (!full || pop);
  assign drop      = arrive && full && !pop;
  assign new_entry = '{flags: cls_flags, word: cls_word};

  // Credit check: stored plus in-flight results must stay below DEPTH to issue
  assign issue_ready = (SUM_W'(count) + SUM_W'(inflight)) < SUM_W'(DEPTH);

  // Next occupancy, read pointer and head entry after this edge's push/pop
  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_nxt = count - CNT_W'(1);
    end else begin
      count_nxt = count;
    end

    rd_nxt = rd_ptr;
    if (pop) begin
      rd_nxt = rd_ptr + PTR_W'(1);
    end else begin
      rd_nxt = rd_ptr;
    end

    // The slot being written becomes the head only when the FIFO drains to it
    head_nxt = mem[rd_nxt];
    if (push && (wr_ptr == rd_nxt)) begin
      head_nxt = new_entry;
    end else begin
      head_nxt = mem[rd_nxt];
    end
  end

  // Valid tracking, credits, pointers, registered head outputs and drop flag
  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe     <= {LATENCY{1'b0}};
      inflight  <= {IF_W{1'b0}};
      wr_ptr    <= {PTR_W{1'b0}};
      rd_ptr    <= {PTR_W{1'b0}};
      count     <= {CNT_W{1'b0}};
      out_valid <= 1'b0;
      out_data  <= {FP_W{1'b0}};
      out_flags <= {FLG_W{1'b0}};
      drop_err  <= 1'b0;
    end else begin
      vpipe <= {vpipe[LATENCY-2:0], issue};

      case ({issue, arrive})
        2'b10:   inflight <= inflight + IF_W'(1);
        2'b01:   inflight <= inflight - IF_W'(1);
        default: inflight <= inflight;
      endcase

      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr <= rd_nxt;
      count  <= count_nxt;

      out_valid <= (count_nxt != {CNT_W{1'b0}});
      // When the FIFO empties the last head value stays on out_data/out_flags
      if (count_nxt != {CNT_W{1'b0}}) begin
        out_data  <= head_nxt.word;
        out_flags <= head_nxt.flags;
      end

      if (drop) begin
        drop_err <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are qualified by the pointers so need no reset
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

endmodule
